// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : note_sequencer
//  Purpose  : Walks a synchronous song ROM of (note code, length) pairs at a
//             tempo-derived tick rate and presents the current note code to
//             the downstream tone generator. Supports start/stop control,
//             looping, rests and an end-of-song marker (length 0).
//  Ports    : clk, reset        - system clock, async active-high reset
//             start, stop       - begin song from entry 0 / abort to idle
//             loop_en           - restart at entry 0 when the song ends
//             rom_addr          - registered ROM address
//             rom_code, rom_len - ROM data, valid one cycle after rom_addr
//             note_code         - current note code (registered)
//             note_valid        - tone audible (not a rest, not idle)
//             note_start        - one-cycle pulse on each new note
//             busy              - sequencer not idle
//             done              - one-cycle pulse when a non-looping song ends
//  Revision : 1.0 - initial release
// ============================================================================
module note_sequencer #(
    parameter int TICK_CYCLES = 18750000,
    parameter int NUM_NOTES   = 32,
    parameter int ADDR_W      = 5,
    parameter int CODE_W      = 5,
    parameter int LEN_W       = 4,
    parameter int REST_CODE   = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [CODE_W-1:0] rom_code,
    input  logic [LEN_W-1:0]  rom_len,
    output logic [CODE_W-1:0] note_code,
    output logic              note_valid,
    output logic              note_start,
    output logic              busy,
    output logic              done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_load  = 2'd2;
    localparam logic [1:0] c_st_play  = 2'd3;

    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_CYCLES - 1);
    localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(NUM_NOTES - 1);
    localparam logic [CODE_W-1:0] c_rest_code = CODE_W'(REST_CODE);
    localparam logic [LEN_W-1:0]  c_len_one   = LEN_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CODE_W-1:0] r_note_code;
    logic              r_note_valid;
    logic              r_note_start;
    logic              r_done;
    logic [TICK_W-1:0] r_tick;
    logic [LEN_W-1:0]  r_remaining;
    // Set when the address rolls past the last ROM entry; the following
    // LOAD then ends the pass even though the ROM holds a real note there.
    logic              r_wrap;

    logic w_end_of_pass;
    assign w_end_of_pass = (rom_len == '0) || r_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_addr       <= '0;
            r_note_code  <= '0;
            r_note_valid <= 1'b0;
            r_note_start <= 1'b0;
            r_done       <= 1'b0;
            r_tick       <= '0;
            r_remaining  <= '0;
            r_wrap       <= 1'b0;
        end else begin
            r_note_start <= 1'b0;
            r_done       <= 1'b0;
            if (stop && (r_state != c_st_idle)) begin
                // Abort wins over everything; address is left where it was.
                r_state      <= c_st_idle;
                r_note_valid <= 1'b0;
                r_wrap       <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start && !stop) begin
                            r_addr  <= '0;
                            r_wrap  <= 1'b0;
                            r_state <= c_st_fetch;
                        end
                    end
                    c_st_fetch: begin
                        r_state <= c_st_load;
                    end
                    c_st_load: begin
                        if (w_end_of_pass) begin
                            r_wrap <= 1'b0;
                            if (loop_en) begin
                                r_addr  <= '0;
                                r_state <= c_st_fetch;
                            end else begin
                                r_done       <= 1'b1;
                                r_note_valid <= 1'b0;
                                r_state      <= c_st_idle;
                            end
                        end else begin
                            r_note_code  <= rom_code;
                            r_note_valid <= (rom_code != c_rest_code);
                            r_note_start <= 1'b1;
                            r_remaining  <= rom_len;
                            r_tick       <= '0;
                            r_state      <= c_st_play;
                        end
                    end
                    c_st_play: begin
                        if (r_tick == c_tick_last) begin
                            r_tick      <= '0;
                            r_remaining <= r_remaining - 1'b1;
                            if (r_remaining == c_len_one) begin
                                r_addr  <= r_addr + 1'b1;
                                r_state <= c_st_fetch;
                                if (r_addr == c_addr_last) begin
                                    r_wrap <= 1'b1;
                                end
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign rom_addr   = r_addr;
    assign note_code  = r_note_code;
    assign note_valid = r_note_valid;
    assign note_start = r_note_start;
    assign done       = r_done;
    assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_sequencer
//  Purpose  : Directed self-checking bench for note_sequencer with a short
//             tick (4 cycles) and an 8-entry synchronous song ROM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    localparam int TICKS = 4;
    localparam int NOTES = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [2:0] rom_addr;
    logic [4:0] rom_code;
    logic [3:0] rom_len;
    logic [4:0] note_code;
    logic       note_valid;
    logic       note_start;
    logic       busy;
    logic       done;

    logic [4:0] mem_code [NOTES];
    logic [3:0] mem_len  [NOTES];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    note_sequencer #(
        .TICK_CYCLES (TICKS),
        .NUM_NOTES   (NOTES),
        .ADDR_W      (3),
        .CODE_W      (5),
        .LEN_W       (4),
        .REST_CODE   (31)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .rom_addr   (rom_addr),
        .rom_code   (rom_code),
        .rom_len    (rom_len),
        .note_code  (note_code),
        .note_valid (note_valid),
        .note_start (note_start),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: data follows the address by one cycle.
    always_ff @(posedge clk) begin
        rom_code <= mem_code[rom_addr];
        rom_len  <= mem_len[rom_addr];
        cyc      <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_demo_rom();
        for (int i = 0; i < NOTES; i++) begin
            mem_code[i] = 5'd0;
            mem_len[i]  = 4'd0;
        end
        mem_code[0] = 5'd3;  mem_len[0] = 4'd2;
        mem_code[1] = 5'd31; mem_len[1] = 4'd1;
        mem_code[2] = 5'd7;  mem_len[2] = 4'd3;
    endtask

    // Pulse start from idle and advance to the first note's load sample.
    task automatic start_song();
        start = 1'b1;
        step();
        start = 1'b0;
        check("fetch_busy", 32'(busy), 1);
        check("fetch_nstart", 32'(note_start), 0);
        step();
        check("load_nstart", 32'(note_start), 0);
        step();
    endtask

    // Checks one full note period, starting at the sample right after its
    // load edge and ending at the sample after the next load edge.
    task automatic expect_note(input int code, input int valid, input int len,
                               input int addr, input bit poke);
        int n;
        n = len * TICKS + 2;
        for (int i = 0; i < n; i++) begin
            check("note_start", 32'(note_start), (i == 0) ? 1 : 0);
            check("note_code", 32'(note_code), code);
            check("note_valid", 32'(note_valid), valid);
            check("busy", 32'(busy), 1);
            check("done", 32'(done), 0);
            check("rom_addr", 32'(rom_addr), (i >= n - 2) ? ((addr + 1) % NOTES) : addr);
            if (poke && (i == 3)) start = 1'b1;
            step();
            start = 1'b0;
        end
    endtask

    // Two-cycle refetch after an end-of-pass that loops back to entry 0.
    task automatic expect_gap(input int code, input int valid);
        for (int i = 0; i < 2; i++) begin
            check("gap_nstart", 32'(note_start), 0);
            check("gap_code", 32'(note_code), code);
            check("gap_valid", 32'(note_valid), valid);
            check("gap_busy", 32'(busy), 1);
            check("gap_done", 32'(done), 0);
            check("gap_addr", 32'(rom_addr), 0);
            step();
        end
    endtask

    task automatic expect_done();
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_valid", 32'(note_valid), 0);
        check("done_nstart", 32'(note_start), 0);
        step();
        check("done_clear", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        load_demo_rom();
        step();
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_code", 32'(note_code), 0);
        check("rst_valid", 32'(note_valid), 0);
        check("rst_nstart", 32'(note_start), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        step();
        check("idle_busy0", 32'(busy), 0);

        // Async reset in the middle of the rest note (address 1).
        start_song();
        expect_note(3, 1, 2, 0, 1'b0);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("arst_addr", 32'(rom_addr), 0);
        check("arst_code", 32'(note_code), 0);
        check("arst_valid", 32'(note_valid), 0);
        check("arst_nstart", 32'(note_start), 0);
        check("arst_done", 32'(done), 0);
        check("arst_busy", 32'(busy), 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_busy", 32'(busy), 0);
            check("post_rst_nstart", 32'(note_start), 0);
            check("post_rst_addr", 32'(rom_addr), 0);
        end

        // Single pass, no loop.
        start_song();
        expect_note(3, 1, 2, 0, 1'b0);
        expect_note(31, 0, 1, 1, 1'b0);
        expect_note(7, 1, 3, 2, 1'b0);
        expect_done();

        // Same pass with start pulses injected mid-note: trace must match.
        step();
        start_song();
        expect_note(3, 1, 2, 0, 1'b1);
        expect_note(31, 0, 1, 1, 1'b1);
        expect_note(7, 1, 3, 2, 1'b1);
        expect_done();

        // Looping three passes; loop_en dropped during the third.
        step();
        loop_en = 1'b1;
        start_song();
        for (int pass = 0; pass < 3; pass++) begin
            expect_note(3, 1, 2, 0, 1'b0);
            if (pass == 2) loop_en = 1'b0;
            expect_note(31, 0, 1, 1, 1'b0);
            expect_note(7, 1, 3, 2, 1'b0);
            if (pass < 2) expect_gap(7, 1);
        end
        expect_done();

        // Stop three cycles into note 7, then start+stop together while idle.
        step();
        start_song();
        expect_note(3, 1, 2, 0, 1'b0);
        expect_note(31, 0, 1, 1, 1'b0);
        check("n7_nstart", 32'(note_start), 1);
        check("n7_code", 32'(note_code), 7);
        step();
        step();
        step();
        stop = 1'b1;
        step();
        check("stop_busy", 32'(busy), 0);
        check("stop_valid", 32'(note_valid), 0);
        check("stop_done", 32'(done), 0);
        check("stop_addr", 32'(rom_addr), 2);
        start = 1'b1;
        step();
        check("stst_busy", 32'(busy), 0);
        check("stst_done", 32'(done), 0);
        start = 1'b0;
        stop  = 1'b0;
        step();
        check("stst_busy2", 32'(busy), 0);
        check("stst_done2", 32'(done), 0);

        // Full ROM of one-tick notes: address wraps 7 -> 0.
        for (int i = 0; i < NOTES; i++) begin
            mem_code[i] = 5'(10 + i);
            mem_len[i]  = 4'd1;
        end
        loop_en = 1'b1;
        step();
        start_song();
        for (int i = 0; i < NOTES; i++) expect_note(10 + i, 1, 1, i, 1'b0);
        expect_gap(17, 1);
        t0 = cyc;
        loop_en = 1'b0;
        for (int i = 0; i < NOTES; i++) expect_note(10 + i, 1, 1, i, 1'b0);
        check("wrap_done_time", 32'(cyc - t0), NOTES * (TICKS + 2));
        expect_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
